// File: rtl/gmii_pll_ctrl.sv
// Bring-up and supervision controller for the GMII TX-clock rPLL, clocked by the 27 MHz reference.
// Sequences PLL reset, qualifies lock with timeout/retry, gates the GMII reset and applies phase steps.
module gmii_pll_ctrl #(
    parameter int unsigned RST_PULSE    = 32,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 27000,
    parameter int unsigned MAX_ATTEMPTS = 4,
    parameter int unsigned HOLD_CYC     = 16
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    input  logic       phase_req,
    input  logic [3:0] phase_val,
    output logic       phase_ack,
    output logic       ready,
    output logic       gmii_rst,
    output logic       fail,
    output logic [3:0] attempt_cnt
);

    localparam int unsigned RST_W = $clog2(RST_PULSE + 1);
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned HLD_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        S_RST_ASSERT  = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_RUN         = 3'd2,
        S_PHASE_HOLD  = 3'd3,
        S_PHASE_APPLY = 3'd4,
        S_FAIL        = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [TMO_W-1:0]   r_timer;
    logic [STB_W-1:0]   r_stable;
    logic [HLD_W-1:0]   r_hold_cnt;
    logic [3:0]         r_attempt;
    logic [3:0]         r_phase_lat;
    logic [3:0]         r_psda;
    logic [3:0]         r_dutyda;
    logic               r_pll_reset;
    logic               r_ready;
    logic               r_gmii_rst;
    logic               r_fail;
    logic               r_ack;

    state_t             w_state_nxt;
    logic               w_lock_s;
    logic [RST_W-1:0]   w_rst_cnt_nxt;
    logic [TMO_W-1:0]   w_timer_nxt;
    logic [STB_W-1:0]   w_stable_nxt;
    logic [HLD_W-1:0]   w_hold_nxt;
    logic [3:0]         w_attempt_nxt;
    logic [3:0]         w_phase_lat_nxt;
    logic [3:0]         w_psda_nxt;
    logic [3:0]         w_dutyda_nxt;
    logic               w_pll_reset_nxt;
    logic               w_ready_nxt;
    logic               w_fail_nxt;
    logic               w_ack_nxt;

    assign w_lock_s = r_sync2;

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        w_state_nxt     = r_state;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_timer_nxt     = r_timer;
        w_stable_nxt    = r_stable;
        w_hold_nxt      = r_hold_cnt;
        w_attempt_nxt   = r_attempt;
        w_phase_lat_nxt = r_phase_lat;
        w_psda_nxt      = r_psda;
        w_dutyda_nxt    = r_dutyda;
        w_ack_nxt       = 1'b0;

        case (r_state)
            S_RST_ASSERT: begin
                if (r_rst_cnt == RST_W'(RST_PULSE - 1)) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                w_timer_nxt  = r_timer + TMO_W'(1);
                w_stable_nxt = w_lock_s ? r_stable + STB_W'(1) : '0;
                // A completed stable run wins over a timeout in the same cycle.
                if (r_stable == STB_W'(LOCK_STABLE)) begin
                    w_state_nxt = S_RUN;
                end else if (r_timer == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    w_attempt_nxt = (r_attempt == 4'd15) ? 4'd15 : r_attempt + 4'd1;
                    w_state_nxt   = (w_attempt_nxt == 4'(MAX_ATTEMPTS)) ? S_FAIL : S_RST_ASSERT;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_RST_ASSERT;
                end else if (phase_req) begin
                    w_state_nxt     = S_PHASE_HOLD;
                    w_phase_lat_nxt = phase_val;
                    w_ack_nxt       = 1'b1;
                end
            end
            S_PHASE_HOLD: begin
                if (r_hold_cnt == HLD_W'(HOLD_CYC - 1)) begin
                    w_state_nxt = S_PHASE_APPLY;
                end else begin
                    w_hold_nxt = r_hold_cnt + HLD_W'(1);
                end
            end
            S_PHASE_APPLY: begin
                // Duty code offset by half a period keeps the output at 50% duty.
                w_psda_nxt   = r_phase_lat;
                w_dutyda_nxt = r_phase_lat + 4'd8;
                w_state_nxt  = S_WAIT_LOCK;
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_RST_ASSERT;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_rst_cnt_nxt = '0;
            w_timer_nxt   = '0;
            w_stable_nxt  = '0;
            w_hold_nxt    = '0;
        end
        if (w_state_nxt == S_RUN) begin
            w_attempt_nxt = 4'd0;
        end

        w_pll_reset_nxt = (w_state_nxt == S_RST_ASSERT) || (w_state_nxt == S_FAIL);
        w_ready_nxt     = (w_state_nxt == S_RUN);
        w_fail_nxt      = (w_state_nxt == S_FAIL);
    end

    // State, counters, synchroniser and output registers.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state     <= S_RST_ASSERT;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_rst_cnt   <= '0;
            r_timer     <= '0;
            r_stable    <= '0;
            r_hold_cnt  <= '0;
            r_attempt   <= 4'd0;
            r_phase_lat <= 4'd0;
            r_psda      <= 4'd0;
            r_dutyda    <= 4'd8;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_gmii_rst  <= 1'b1;
            r_fail      <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync1     <= pll_lock;
            r_sync2     <= r_sync1;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_stable    <= w_stable_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_attempt   <= w_attempt_nxt;
            r_phase_lat <= w_phase_lat_nxt;
            r_psda      <= w_psda_nxt;
            r_dutyda    <= w_dutyda_nxt;
            r_pll_reset <= w_pll_reset_nxt;
            r_ready     <= w_ready_nxt;
            r_gmii_rst  <= ~w_ready_nxt;
            r_fail      <= w_fail_nxt;
            r_ack       <= w_ack_nxt;
        end
    end

    assign pll_reset   = r_pll_reset;
    assign psda        = r_psda;
    assign dutyda      = r_dutyda;
    assign phase_ack   = r_ack;
    assign ready       = r_ready;
    assign gmii_rst    = r_gmii_rst;
    assign fail        = r_fail;
    assign attempt_cnt = r_attempt;

endmodule

// File: tb/tb_gmii_pll_ctrl.sv
// Scoreboard bench for gmii_pll_ctrl: a PLL behaviour model plus a mode-level reference model
// predict every cycle's outputs; a monitor compares them against the DUT.
module tb_gmii_pll_ctrl;

    localparam int RST_PULSE    = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 50;
    localparam int MAX_ATTEMPTS = 2;
    localparam int HOLD_CYC     = 16;

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_RUN   = 2;
    localparam int M_HOLD  = 3;
    localparam int M_APPLY = 4;
    localparam int M_FAIL  = 5;

    typedef struct packed {
        logic       pr;
        logic       rdy;
        logic       grst;
        logic       fl;
        logic       ack;
        logic [3:0] ps;
        logic [3:0] dd;
        logic [3:0] at;
    } obs_t;

    logic       clkin;
    logic       rst;
    logic       pll_lock;
    logic       pll_reset;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic       phase_req;
    logic [3:0] phase_val;
    logic       phase_ack;
    logic       ready;
    logic       gmii_rst;
    logic       fail;
    logic [3:0] attempt_cnt;

    gmii_pll_ctrl #(
        .RST_PULSE   (RST_PULSE),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_ATTEMPTS(MAX_ATTEMPTS),
        .HOLD_CYC    (HOLD_CYC)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .psda       (psda),
        .dutyda     (dutyda),
        .phase_req  (phase_req),
        .phase_val  (phase_val),
        .phase_ack  (phase_ack),
        .ready      (ready),
        .gmii_rst   (gmii_rst),
        .fail       (fail),
        .attempt_cnt(attempt_cnt)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    obs_t exp_q[$];

    // Reference model state (modes, time in mode, lock run length, failed attempts).
    int m_mode  = M_PULSE;
    int t_in    = 0;
    int run_len = 0;
    int fails   = 0;
    int m_psda  = 0;
    int m_lat   = 0;
    bit m_ack   = 0;
    int lock_pipe[$];

    // Stimulus knobs.
    bit       b_rst      = 1;
    bit       b_req      = 0;
    logic [3:0] b_val    = 4'd0;
    int       lock_mode  = 0;   // 0: follow PLL model, 1: forced low
    int       lock_delay = 10;
    int       glitch_at  = -1;
    int       since      = 0;
    bit       last_pr    = 1;
    bit       last_ack   = 0;

    function automatic void model_step(input bit r, input bit lk, input bit rq, input int v);
        int ls;
        int nm;
        if (r) begin
            m_mode = M_PULSE; t_in = 0; run_len = 0; fails = 0;
            m_psda = 0; m_lat = 0; m_ack = 0;
            lock_pipe = {0, 0};
            return;
        end
        ls = lock_pipe.pop_front();   // lock as seen two cycles late
        lock_pipe.push_back(int'(lk));
        nm = m_mode;
        m_ack = 0;
        case (m_mode)
            M_PULSE: if (t_in + 1 == RST_PULSE) nm = M_WAIT;
            M_WAIT: begin
                if (run_len >= LOCK_STABLE) nm = M_RUN;
                else if (t_in + 1 == LOCK_TIMEOUT) begin
                    fails = (fails < 15) ? fails + 1 : 15;
                    nm = (fails == MAX_ATTEMPTS) ? M_FAIL : M_PULSE;
                end
            end
            M_RUN: begin
                if (ls == 0) nm = M_PULSE;
                else if (rq) begin nm = M_HOLD; m_lat = v; m_ack = 1; end
            end
            M_HOLD:  if (t_in + 1 == HOLD_CYC) nm = M_APPLY;
            M_APPLY: begin m_psda = m_lat; nm = M_WAIT; end
            default: nm = m_mode;
        endcase
        if (m_mode == M_WAIT) run_len = (ls != 0) ? run_len + 1 : 0;
        if (nm != m_mode) begin t_in = 0; run_len = 0; end
        else t_in = t_in + 1;
        if (nm == M_RUN) fails = 0;
        m_mode = nm;
    endfunction

    // One cycle: PLL model decides lock, requester reacts to ack, model predicts, inputs driven.
    task automatic tick();
        obs_t e;
        bit   lk;
        @(negedge clkin);
        if (last_pr) since = 0;
        else since = since + 1;
        lk = (lock_mode == 1) ? 1'b0 : (since >= lock_delay);
        if (glitch_at >= 0 && since == glitch_at) lk = 1'b0;
        if (b_req && last_ack) b_req = 1'b0;
        model_step(b_rst, lk, b_req, int'(b_val));
        e.pr   = (m_mode == M_PULSE) || (m_mode == M_FAIL);
        e.rdy  = (m_mode == M_RUN);
        e.grst = (m_mode != M_RUN);
        e.fl   = (m_mode == M_FAIL);
        e.ack  = m_ack;
        e.ps   = 4'(m_psda);
        e.dd   = 4'((m_psda + 8) % 16);
        e.at   = 4'(fails);
        exp_q.push_back(e);
        last_pr  = e.pr;
        last_ack = e.ack;
        rst       = b_rst;
        pll_lock  = lk;
        phase_req = b_req;
        phase_val = b_val;
        cyc = cyc + 1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_mode(input int target, input int limit);
        int n = 0;
        while (m_mode != target && m_mode != M_FAIL && n < limit) begin tick(); n++; end
        checks = checks + 1;
        if (m_mode != target && m_mode != M_FAIL) begin
            errors = errors + 1;
            $display("FAIL wait expired t=%0t target=%0d mode=%0d after %0d cycles",
                     $time, target, m_mode, n);
        end
    endtask

    // Direct check of the reset values on the edge after rst was driven high.
    task automatic check_reset();
        @(posedge clkin);
        #1;
        checks = checks + 1;
        if (pll_reset !== 1'b1 || gmii_rst !== 1'b1 || ready !== 1'b0 || fail !== 1'b0 ||
            psda !== 4'd0 || dutyda !== 4'd8 || phase_ack !== 1'b0 || attempt_cnt !== 4'd0) begin
            errors = errors + 1;
            $display("FAIL reset values t=%0t pr=%b grst=%b rdy=%b fail=%b psda=%0d duty=%0d ack=%b att=%0d",
                     $time, pll_reset, gmii_rst, ready, fail, psda, dutyda, phase_ack, attempt_cnt);
        end
    endtask

    task automatic reset_pulse(input int n);
        b_rst = 1; ticks(n); check_reset(); b_rst = 0;
    endtask

    task automatic phase_change(input logic [3:0] v);
        b_req = 1; b_val = v;
        wait_mode(M_HOLD, 20);
        wait_mode(M_RUN, 200);
    endtask

    task automatic lock_loss();
        lock_mode = 1; ticks(2); lock_mode = 0;
        ticks(4);
        wait_mode(M_RUN, 200);
    endtask

    // Monitor: compare DUT outputs just after each edge against the oldest prediction.
    always @(posedge clkin) begin
        obs_t e;
        obs_t a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {pll_reset, ready, gmii_rst, fail, phase_ack, psda, dutyda, attempt_cnt};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL outputs t=%0t got pr=%b rdy=%b grst=%b fail=%b ack=%b psda=%0d duty=%0d att=%0d exp pr=%b rdy=%b grst=%b fail=%b ack=%b psda=%0d duty=%0d att=%0d",
                         $time, a.pr, a.rdy, a.grst, a.fl, a.ack, a.ps, a.dd, a.at,
                         e.pr, e.rdy, e.grst, e.fl, e.ack, e.ps, e.dd, e.at);
            end
        end
    end

    initial begin
        int sel;
        rst = 1'b1; pll_lock = 1'b0; phase_req = 1'b0; phase_val = 4'd0;
        lock_pipe = {0, 0};

        // Bring-up with lock 10 cycles after reset release.
        reset_pulse(3);
        lock_delay = 10;
        wait_mode(M_RUN, 200);
        ticks(5);

        // Single-cycle glitch after 5 locked cycles.
        reset_pulse(2);
        glitch_at = 15;
        wait_mode(M_RUN, 200);
        glitch_at = -1;
        ticks(3);

        // Phase change to 5, lock loss keeps psda, then phase 12.
        phase_change(4'd5);
        ticks(3);
        lock_loss();
        ticks(3);
        phase_change(4'd12);
        ticks(3);

        // Timeout path to sticky fail.
        lock_mode = 1;
        wait_mode(M_FAIL, 400);
        ticks(20);
        lock_mode = 0;

        // Reset during phase hold, then full bring-up.
        reset_pulse(2);
        wait_mode(M_RUN, 200);
        b_req = 1; b_val = 4'd9;
        wait_mode(M_HOLD, 20);
        ticks(6);
        reset_pulse(1);
        wait_mode(M_RUN, 200);
        ticks(3);

        // Randomised scenarios.
        for (int it = 0; it < 30; it++) begin
            reset_pulse(int'($urandom_range(3, 1)));
            lock_delay = int'($urandom_range(48, 1));
            glitch_at  = ($urandom_range(3, 0) == 0) ? lock_delay + int'($urandom_range(7, 0)) : -1;
            if ($urandom_range(3, 0) == 0) begin
                b_req = 1; b_val = 4'($urandom_range(15, 0));
            end
            wait_mode(M_RUN, 300);
            glitch_at = -1;
            ticks(3);
            wait_mode(M_RUN, 200);
            if (m_mode == M_RUN && !b_req) begin
                sel = int'($urandom_range(2, 0));
                if (sel == 0) begin
                    phase_change(4'($urandom_range(15, 0)));
                end else if (sel == 1) begin
                    lock_loss();
                end else begin
                    b_req = 1; b_val = 4'($urandom_range(15, 0));
                    wait_mode(M_HOLD, 20);
                    ticks(int'($urandom_range(12, 1)));
                    reset_pulse(1);
                    wait_mode(M_RUN, 200);
                end
            end
            ticks(int'($urandom_range(6, 1)));
        end

        b_req = 0;
        ticks(2);
        @(posedge clkin);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmii_pll_ctrl.md
# gmii_pll_ctrl

Bring-up and supervision controller for the GMII transmit-clock rPLL. It runs on the 27 MHz reference clock, which stays valid while the PLL output does not, and synchronises the raw PLL `LOCK`. The block sequences the PLL reset, qualifies lock with a timeout and a retry limit, and holds the GMII domain in reset until the clock is stable. It also performs glitch-safe dynamic phase changes on `PSDA`/`DUTYDA` for TX clock-to-data alignment.

## Interface
Parameters:
- `RST_PULSE`, default 32: cycles `pll_reset` is held high per attempt.
- `LOCK_STABLE`, default 256: consecutive synchronised lock-high cycles required before the lock is accepted.
- `LOCK_TIMEOUT`, default 27000 (1 ms): cycles allowed in WAIT_LOCK per attempt.
- `MAX_ATTEMPTS`, default 4: failed attempts allowed before entering FAIL. Range 1..15.
- `HOLD_CYC`, default 16: cycles `gmii_rst` is held before a new `psda` is applied.

Ports:
- `clkin`, in, 1: 27 MHz reference clock; the only clock in the block.
- `rst`, in, 1: synchronous, active-high reset.
- `pll_lock`, in, 1: raw rPLL `LOCK`, asynchronous; passed through a 2-flop synchroniser to give `lock_s`.
- `pll_reset`, out, 1: drives rPLL `RESET`.
- `psda`, out, 4: drives rPLL `PSDA` (phase step).
- `dutyda`, out, 4: drives rPLL `DUTYDA`.
- `phase_req`, in, 1: level request for a phase change.
- `phase_val`, in, 4: requested phase; sampled when the request is accepted.
- `phase_ack`, out, 1: one-cycle pulse when a request is accepted.
- `ready`, out, 1: PLL locked and stable; the GMII domain is released.
- `gmii_rst`, out, 1: active-high reset for the GMII domain; equal to `~ready`.
- `fail`, out, 1: attempt limit exhausted; sticky until `rst`.
- `attempt_cnt`, out, 4: failed attempts since the last time RUN was entered.

## Operation
- States: RST_ASSERT, WAIT_LOCK, RUN, PHASE_HOLD, PHASE_APPLY, FAIL.
- RST_ASSERT:
  - `pll_reset`=1.
  - After `RST_PULSE` cycles, go to WAIT_LOCK and clear the timer and the stable counter.
- WAIT_LOCK:
  - The timer increments every cycle.
  - The stable counter increments while `lock_s`=1 and clears on `lock_s`=0.
  - When the stable counter reaches `LOCK_STABLE`, go to RUN. This check takes priority over the timeout in the same cycle.
  - When the timer reaches `LOCK_TIMEOUT`-1:
    - `attempt_cnt`++.
    - If the new value equals `MAX_ATTEMPTS`, go to FAIL; otherwise go to RST_ASSERT.
- RUN:
  - `ready`=1 and `attempt_cnt` is cleared.
  - `lock_s`=0 goes to RST_ASSERT. This has priority over `phase_req`.
  - `phase_req`=1 goes to PHASE_HOLD, latches `phase_val`, and pulses `phase_ack`.
- PHASE_HOLD:
  - `gmii_rst`=1; `pll_reset` stays 0.
  - After `HOLD_CYC` cycles, go to PHASE_APPLY.
- PHASE_APPLY (1 cycle):
  - `psda` <= latched value; `dutyda` <= (latched + 8) mod 16, which keeps the duty cycle at 50%.
  - Go to WAIT_LOCK. The normal stable and timeout rules then apply.
- FAIL:
  - `pll_reset`=1, `gmii_rst`=1, `fail`=1.
  - Only `rst` exits this state.
- `phase_req` outside RUN is not accepted; it stays pending because it is a level.
  - The requester drops `phase_req` in the cycle after `phase_ack`.
  - A request held high is accepted again at the next RUN entry.
- `psda`/`dutyda` persist across lock loss and retries. Only `rst` restores 0/8.
- Counter widths: `$clog2(param+1)`. `attempt_cnt` saturates at 15.

## Timing
- Reset values (all outputs, and while `rst`=1):
  - `pll_reset`=1, `gmii_rst`=1, `ready`=0, `fail`=0.
  - `psda`=0, `dutyda`=8, `phase_ack`=0, `attempt_cnt`=0.
  - state=RST_ASSERT, synchroniser flops=0.
- After `rst` falls, `pll_reset` stays high for exactly `RST_PULSE` cycles.
- `pll_lock` to `lock_s` latency: 2 cycles.
- `ready` rises on the cycle after the `LOCK_STABLE`-th consecutive `lock_s`=1 sample.
- Lock loss in RUN: `ready` falls and `pll_reset` rises 3 cycles after `pll_lock` falls (2 synchroniser + 1 registered).
- Phase change: `phase_ack` is registered and appears the cycle after `phase_req` is seen in RUN; `ready` falls in the same cycle. `psda` updates `HOLD_CYC`+1 cycles after `phase_ack`.
- `rst` mid-operation, including during PHASE_HOLD, forces the reset values on the next edge.
- All outputs are registered.

## Test plan
Test parameters: `RST_PULSE`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=50, `MAX_ATTEMPTS`=2, `HOLD_CYC`=16.

1. Bring-up: the PLL model raises `pll_lock` 10 cycles after `pll_reset` falls -> `pll_reset` was high exactly 4 cycles; `ready`=1 and `gmii_rst`=0 exactly 10+2+8 cycles after `pll_reset` fell.
2. Lock glitch: `pll_lock` drops for 1 cycle after 5 stable cycles -> the stable count restarts; `ready` is delayed accordingly; no new `pll_reset` pulse.
3. Timeout: `pll_lock` held 0 -> two 4-cycle `pll_reset` pulses, `attempt_cnt` goes 1 then 2, then `fail`=1 with `pll_reset` held at 1; `fail` holds until `rst`.
4. Phase change: in RUN, `phase_req`=1 with `phase_val`=5 -> single `phase_ack`; `ready`=0 for at least 17 cycles; `psda`=5 and `dutyda`=13; `ready` returns after relock. Repeat with `phase_val`=12 -> `dutyda`=4.
5. Lock loss in RUN with `psda`=5 -> `ready` falls 3 cycles after `pll_lock` falls; one `pll_reset` pulse; `psda` stays 5; `ready` recovers; `attempt_cnt`=0.
6. `rst` pulsed during PHASE_HOLD -> next cycle shows all reset values (`psda`=0, `dutyda`=8, `pll_reset`=1), then a full bring-up sequence follows.
